// File: rtl/fp_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_adder_pkg                                                       |
// | Shared widths, FSM encoding and lane mapping for the fp adder.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fp_adder_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int SETUP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // serial1..serial4 carry operands d..a
  localparam int c_LANE_D    = 0;
  localparam int c_LANE_C    = 1;
  localparam int c_LANE_B    = 2;
  localparam int c_LANE_A    = 3;
  localparam int c_NUM_LANES = 4;

endpackage
`default_nettype wire

// File: rtl/fp_serial_lane.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_serial_lane                                                     |
// | Indexed shadow register for one LSB-first serial lane.             |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fp_serial_lane #(
  parameter int W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [$clog2(W)-1:0] i_idx,
  input  logic                 i_bit,
  output logic [W-1:0]         o_next
);

  logic [W-1:0] r_shadow;

  // o_next already includes the bit being captured this cycle, so the
  // final bit of a frame can be forwarded on the completing edge.
  always_comb begin
    o_next = r_shadow;
    if (i_en) begin
      o_next[i_idx] = i_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (i_clr) begin
      r_shadow <= '0;
    end else begin
      r_shadow <= o_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_input_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_input_deserializer                                              |
// | Serial-to-parallel operand front-end with valid/ready handoff.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fp_input_deserializer
  import fp_adder_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SETUP_W = SETUP_W_DEF
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               serial1_in,
  input  logic               serial2_in,
  input  logic               serial3_in,
  input  logic               serial4_in,
  input  logic               setup_serial_in,
  input  logic               wr_in,
  input  logic               op_ready_in,
  output logic               input_rdy,
  output logic               op_valid,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   op_c,
  output logic [WIDTH-1:0]   op_d,
  output logic [SETUP_W-1:0] setup_out,
  output logic               frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = $clog2(SETUP_W);
  localparam logic [CW-1:0] c_CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [CW:0]   c_SETUP_LIM = (CW + 1)'(SETUP_W);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic                 w_cap;
  logic                 w_done;
  logic                 w_clr;
  logic                 w_err;
  logic                 w_setup_en;
  logic                 r_full_wr_seen;
  logic                 r_frame_err;
  logic                 w_ser        [c_NUM_LANES];
  logic [WIDTH-1:0]     w_lane_next  [c_NUM_LANES];
  logic [WIDTH-1:0]     r_op         [c_NUM_LANES];
  logic [SETUP_W-1:0]   w_setup_next;
  logic [SETUP_W-1:0]   r_setup;

  assign w_ser[c_LANE_D] = serial1_in;
  assign w_ser[c_LANE_C] = serial2_in;
  assign w_ser[c_LANE_B] = serial3_in;
  assign w_ser[c_LANE_A] = serial4_in;

  for (genvar gi = 0; gi < c_NUM_LANES; gi++) begin : g_lane
    fp_serial_lane #(.W(WIDTH)) u_lane (
      .clk    (clk_in),
      .rst_n  (rst_in),
      .i_clr  (w_clr),
      .i_en   (w_cap),
      .i_idx  (r_cnt),
      .i_bit  (w_ser[gi]),
      .o_next (w_lane_next[gi])
    );
  end

  // Setup bits beyond SETUP_W are ignored rather than wrapping the index.
  assign w_setup_en = w_cap && ({1'b0, r_cnt} < c_SETUP_LIM);

  fp_serial_lane #(.W(SETUP_W)) u_setup (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .i_clr  (w_clr),
    .i_en   (w_setup_en),
    .i_idx  (r_cnt[SW-1:0]),
    .i_bit  (setup_serial_in),
    .o_next (w_setup_next)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_done      = 1'b0;
    w_clr       = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wr_in) begin
          w_cap       = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (wr_in) begin
          w_cap = 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            w_done      = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = ST_FULL;
          end
        end else begin
          w_clr       = 1'b1;
          w_err       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FULL: begin
        // Only the first strobe cycle seen while holding a set is flagged.
        w_err = wr_in && !r_full_wr_seen;
        if (op_ready_in) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cnt          <= '0;
      r_full_wr_seen <= 1'b0;
      r_frame_err    <= 1'b0;
      r_setup        <= '0;
      for (int i = 0; i < c_NUM_LANES; i++) begin
        r_op[i] <= '0;
      end
    end else begin
      r_frame_err <= w_err;
      if (w_cap && !w_done) begin
        r_cnt <= (r_cnt == c_CNT_LAST) ? r_cnt : r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if ((r_state == ST_FULL) && (w_state_nxt == ST_FULL)) begin
        r_full_wr_seen <= r_full_wr_seen | wr_in;
      end else begin
        r_full_wr_seen <= 1'b0;
      end
      if (w_done) begin
        for (int i = 0; i < c_NUM_LANES; i++) begin
          r_op[i] <= w_lane_next[i];
        end
        r_setup <= w_setup_next;
      end
    end
  end

  assign input_rdy = (r_state == ST_IDLE);
  assign op_valid  = (r_state == ST_FULL);
  assign op_a      = r_op[c_LANE_A];
  assign op_b      = r_op[c_LANE_B];
  assign op_c      = r_op[c_LANE_C];
  assign op_d      = r_op[c_LANE_D];
  assign setup_out = r_setup;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fp_input_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fp_input_deserializer                                           |
// | Scoreboard bench for the serial operand front-end.                 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fp_input_deserializer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        serial1_in, serial2_in, serial3_in, serial4_in;
  logic        setup_serial_in, wr_in, op_ready_in;
  logic        input_rdy, op_valid, frame_err;
  logic [15:0] op_a, op_b, op_c, op_d;
  logic [7:0]  setup_out;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic [7:0]  s;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp  = 0;
  int   n_mis  = 0;
  int   n_errp = 0;
  int   n_xfer = 0;
  int   e0;

  always #5 clk_in = ~clk_in;

  fp_input_deserializer u_dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .serial1_in      (serial1_in),
    .serial2_in      (serial2_in),
    .serial3_in      (serial3_in),
    .serial4_in      (serial4_in),
    .setup_serial_in (setup_serial_in),
    .wr_in           (wr_in),
    .op_ready_in     (op_ready_in),
    .input_rdy       (input_rdy),
    .op_valid        (op_valid),
    .op_a            (op_a),
    .op_b            (op_b),
    .op_c            (op_c),
    .op_d            (op_d),
    .setup_out       (setup_out),
    .frame_err       (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pops one expected set per accepted transfer and counts error pulses.
  always @(negedge clk_in) begin
    exp_t e;
    if (frame_err === 1'b1) n_errp++;
    if (op_valid === 1'b1 && op_ready_in === 1'b1) begin
      check("xfer_pending", 32'(q_exp.size() > 0), 1);
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        n_xfer++;
        check("xfer_a", op_a, e.a);
        check("xfer_b", op_b, e.b);
        check("xfer_c", op_c, e.c);
        check("xfer_d", op_d, e.d);
        check("xfer_setup", setup_out, e.s);
      end
    end
  end

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d,
                            input logic [7:0] s, input int nbits,
                            input bit fill, input bit push);
    if (push) q_exp.push_back(exp_t'{a, b, c, d, s});
    for (int i = 0; i < nbits; i++) begin
      wr_in           = 1'b1;
      serial4_in      = a[i[3:0]];
      serial3_in      = b[i[3:0]];
      serial2_in      = c[i[3:0]];
      serial1_in      = d[i[3:0]];
      setup_serial_in = (i < 8) ? s[i[2:0]] : fill;
      @(posedge clk_in); #1;
      if (i == 0) check("rdy_low_after_first_edge", input_rdy, 0);
    end
    wr_in = 1'b0;
    {serial1_in, serial2_in, serial3_in, serial4_in, setup_serial_in} = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b0;
    wr_in = 1'b0;
    op_ready_in = 1'b0;
    {serial1_in, serial2_in, serial3_in, serial4_in, setup_serial_in} = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b1;
    @(posedge clk_in); #1;
    check("rst_input_rdy", input_rdy, 1);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_d", op_d, 0);
    check("rst_setup", setup_out, 0);
    check("rst_frame_err", frame_err, 0);

    // Basic frame, core always ready
    op_ready_in = 1'b1;
    send_frame(16'h3C00, 16'h3C00, 16'h0000, 16'h0000, 8'h1E, 16, 1'b0, 1'b1);
    check("f1_valid", op_valid, 1);
    check("f1_setup", setup_out, 8'h1E);
    @(posedge clk_in); #1;
    check("f1_rdy_back", input_rdy, 1);
    check("f1_valid_drop", op_valid, 0);

    // Setup ignored past bit 7; stall the core for 5 cycles
    op_ready_in = 1'b0;
    send_frame(16'h4000, 16'h4000, 16'h3C00, 16'h1111, 8'h1C, 16, 1'b1, 1'b1);
    repeat (5) begin
      @(posedge clk_in); #1;
      check("hold_valid", op_valid, 1);
      check("hold_a", op_a, 16'h4000);
      check("hold_d", op_d, 16'h1111);
      check("hold_setup", setup_out, 8'h1C);
    end
    op_ready_in = 1'b1;
    @(posedge clk_in); #1;
    check("f2_rdy_back", input_rdy, 1);

    // Abort after 7 bits
    e0 = n_errp;
    send_frame(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF, 7, 1'b0, 1'b0);
    @(posedge clk_in); #1;
    check("abort_idle", input_rdy, 1);
    check("abort_valid", op_valid, 0);
    check("abort_keep_a", op_a, 16'h4000);
    check("abort_keep_c", op_c, 16'h3C00);
    check("abort_keep_d", op_d, 16'h1111);
    check("abort_keep_setup", setup_out, 8'h1C);
    @(posedge clk_in); #1;
    check("abort_err_once", n_errp - e0, 1);

    // Strobe while FULL
    op_ready_in = 1'b0;
    send_frame(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 8'h33, 16, 1'b0, 1'b1);
    e0 = n_errp;
    repeat (3) begin
      wr_in = 1'b1;
      {serial1_in, serial2_in, serial3_in, serial4_in} = 4'($urandom);
      @(posedge clk_in); #1;
    end
    wr_in = 1'b0;
    @(posedge clk_in); #1;
    check("full_err_once", n_errp - e0, 1);
    check("full_keep_a", op_a, 16'h1234);
    check("full_keep_b", op_b, 16'h5678);
    check("full_keep_c", op_c, 16'h9ABC);
    check("full_keep_d", op_d, 16'hDEF0);
    check("full_still_valid", op_valid, 1);
    op_ready_in = 1'b1;
    @(posedge clk_in); #1;
    check("full_rdy_back", input_rdy, 1);

    // Reset during bit 9
    send_frame(16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 8'hAA, 9, 1'b0, 1'b0);
    rst_in = 1'b0;
    #1;
    check("midrst_rdy", input_rdy, 1);
    check("midrst_valid", op_valid, 0);
    check("midrst_a", op_a, 0);
    check("midrst_b", op_b, 0);
    check("midrst_setup", setup_out, 0);
    @(negedge clk_in) rst_in = 1'b1;
    @(posedge clk_in); #1;
    send_frame(16'h4200, 16'h4200, 16'h4200, 16'h4200, 8'h98, 16, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    check("postrst_rdy", input_rdy, 1);

    // Back-to-back with a single idle cycle
    e0 = n_errp;
    send_frame(16'h4880, 16'hABCD, 16'h0F0F, 16'h8001, 8'h5A, 16, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    send_frame(16'h3C00, 16'h7BFF, 16'h0001, 16'hFFFF, 8'hA5, 16, 1'b0, 1'b1);
    @(posedge clk_in); #1;
    check("b2b_no_err", n_errp - e0, 0);
    check("b2b_rdy", input_rdy, 1);

    repeat (2) @(posedge clk_in);
    #1;
    check("xfer_count", n_xfer, 6);
    check("queue_empty", q_exp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
